// File: rtl/md_unit_param_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg: shared types and helpers for the parametrised multiply/divide unit.
//
// Contents:
//   md_op_t     - 4-bit operation encoding driven by the E stage
//   op_kind_t   - internal classification used by the accept logic
//   op_kind()   - decode md_op_t into op_kind_t
//   cnt_width() - width of the busy down-counter for the given latencies
//
// Configuration macro: MD_UNIT_ACCUM_EN
//   Defined   : MADD/MADDU/MSUB/MSUBU decode as long multiply-class ops.
//   Undefined : those four codes decode as no-ops (no busy, no state change).
// ---------------------------------------------------------------------------
package md_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MTHI  = 4'd5,
    MTLO  = 4'd6,
    MADD  = 4'd7,
    MADDU = 4'd8,
    MSUB  = 4'd9,
    MSUBU = 4'd10
  } md_op_t;

  typedef enum logic [2:0] {
    K_NONE,
    K_MUL,
    K_DIV,
    K_MTHI,
    K_MTLO
  } op_kind_t;

  // Undefined codes fall into K_NONE and are therefore never accepted.
  function automatic op_kind_t op_kind(md_op_t op);
    op_kind_t k;
    k = K_NONE;
    case (op)
      MULT, MULTU: k = K_MUL;
      DIV, DIVU:   k = K_DIV;
      MTHI:        k = K_MTHI;
      MTLO:        k = K_MTLO;
`ifdef MD_UNIT_ACCUM_EN
      MADD, MADDU, MSUB, MSUBU: k = K_MUL;
`endif
      default:     k = K_NONE;
    endcase
    return k;
  endfunction

  // One extra bit above clog2(max latency) so the largest latency always fits.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/md_unit_param_if.sv
// ---------------------------------------------------------------------------
// md_unit_param_if: E-stage <-> multiply/divide unit connection.
//
// Signals:
//   start  - one-cycle request; md_op/d1/d2 valid this cycle
//   md_op  - operation code (md_pkg::md_op_t)
//   d1, d2 - forwarded rs / rt operands
//   req    - exception/interrupt taken this cycle; suppresses the request
//   busy   - long operation in progress
//   hi, lo - architectural HI/LO registers
//
// Modports:
//   master - E-stage side (drives request, observes busy/hi/lo)
//   slave  - MD unit side
// ---------------------------------------------------------------------------
interface md_unit_param_if #(
  parameter int unsigned WIDTH = 32
);
  import md_pkg::*;

  logic             start;
  md_op_t           md_op;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             req;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, d1, d2, req,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, d1, d2, req,
    output busy, hi, lo
  );

endinterface

// File: rtl/md_unit_param_arith.sv
// ---------------------------------------------------------------------------
// md_arith: purely combinational datapath of the multiply/divide unit.
//
// Given an operation, the operands and the current HI/LO, produces the value
// {hi_out, lo_out} that HI/LO should take once the operation completes.
//
// Ports:
//   op      in  md_op_t  operation code
//   d1, d2  in  WIDTH    operands (d1 = dividend / multiplicand / MTxx data)
//   hi_in   in  WIDTH    current HI (accumulate base, div0 result)
//   lo_in   in  WIDTH    current LO
//   hi_out  out WIDTH    next HI
//   lo_out  out WIDTH    next LO
//
// Special cases handled here:
//   - divide by zero: HI/LO unchanged
//   - signed overflow (-2^(WIDTH-1) / -1): LO = -2^(WIDTH-1), HI = 0
//
// Configuration macro: MD_UNIT_ACCUM_EN enables MADD/MADDU/MSUB/MSUBU,
// computed as {hi,lo} +/- product modulo 2^(2*WIDTH).
// ---------------------------------------------------------------------------
module md_arith
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  md_op_t           op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned      W2      = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    prod_u;
`ifdef MD_UNIT_ACCUM_EN
  logic [W2-1:0]    hilo;
`endif
  logic             div0;
  logic             ovf;
  logic [WIDTH-1:0] div_u;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] sq_mag;
  logic [WIDTH-1:0] sr_mag;
  logic [WIDTH-1:0] sq;
  logic [WIDTH-1:0] sr;

  always_comb begin
    // Extending both operands to 2*WIDTH before multiplying gives the exact
    // signed/unsigned product in the low 2*WIDTH bits.
    prod_s = {{WIDTH{d1[WIDTH-1]}}, d1} * {{WIDTH{d2[WIDTH-1]}}, d2};
    prod_u = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};
`ifdef MD_UNIT_ACCUM_EN
    hilo   = {hi_in, lo_in};
`endif

    div0 = (d2 == '0);
    ovf  = (d1 == MIN_NEG) && (d2 == '1);

    // Divisor forced to 1 on div0 so the dividers never see zero; the result
    // is discarded in that case anyway.
    div_u = div0 ? WIDTH'(1) : d2;
    mag1  = d1[WIDTH-1] ? (~d1 + WIDTH'(1)) : d1;
    mag2  = div0 ? WIDTH'(1) : (d2[WIDTH-1] ? (~d2 + WIDTH'(1)) : d2);

    uq     = d1 / div_u;
    ur     = d1 % div_u;
    sq_mag = mag1 / mag2;
    sr_mag = mag1 % mag2;

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    sq = (d1[WIDTH-1] ^ d2[WIDTH-1]) ? (~sq_mag + WIDTH'(1)) : sq_mag;
    sr = d1[WIDTH-1] ? (~sr_mag + WIDTH'(1)) : sr_mag;

    hi_out = hi_in;
    lo_out = lo_in;

    case (op)
      MULT:  {hi_out, lo_out} = prod_s;
      MULTU: {hi_out, lo_out} = prod_u;
      DIV: begin
        if (div0) begin
          hi_out = hi_in;
          lo_out = lo_in;
        end else if (ovf) begin
          hi_out = '0;
          lo_out = MIN_NEG;
        end else begin
          hi_out = sr;
          lo_out = sq;
        end
      end
      DIVU: begin
        if (!div0) begin
          hi_out = ur;
          lo_out = uq;
        end
      end
      MTHI:  hi_out = d1;
      MTLO:  lo_out = d1;
`ifdef MD_UNIT_ACCUM_EN
      MADD:  {hi_out, lo_out} = hilo + prod_s;
      MADDU: {hi_out, lo_out} = hilo + prod_u;
      MSUB:  {hi_out, lo_out} = hilo - prod_s;
      MSUBU: {hi_out, lo_out} = hilo - prod_u;
`endif
      default: begin
        hi_out = hi_in;
        lo_out = lo_in;
      end
    endcase
  end

endmodule

// File: rtl/md_unit_param.sv
// ---------------------------------------------------------------------------
// md_unit_param: parametrised multiply/divide unit for the E stage.
//
// Parameters:
//   WIDTH   - operand / HI / LO width (>= 8, even)
//   MUL_LAT - busy cycles for multiply-class ops (>= 1)
//   DIV_LAT - busy cycles for divide ops (>= 1)
//
// Ports:
//   clk    in  clock, all state on rising edge
//   reset  in  synchronous, active-high; clears all state, aborts any op
//   bus    slave modport of md_unit_param_if (start, md_op, d1, d2, req,
//          busy, hi, lo)
//
// An op is accepted when start && !req && !busy && md_op decodes to a real
// operation. The result of a long op is computed at the accept edge, held in
// pending registers, and committed to HI/LO at the edge that ends the last
// busy cycle. MTHI/MTLO write immediately and never raise busy. The hazard
// unit stalls any MD instruction in D while start|busy.
//
// Configuration macro: MD_UNIT_ACCUM_EN (enables MADD/MADDU/MSUB/MSUBU).
// ---------------------------------------------------------------------------
module md_unit_param
  import md_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic            clk,
  input  logic            reset,
  md_unit_param_if.slave  bus
);

  localparam int unsigned CW = cnt_width(MUL_LAT, DIV_LAT);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] pend_hi_q;
  logic [WIDTH-1:0] pend_lo_q;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  op_kind_t         kind;
  logic             busy_w;
  logic             accept;

  assign kind   = op_kind(bus.md_op);
  assign busy_w = (cnt_q != '0);
  assign accept = bus.start && !bus.req && !busy_w && (kind != K_NONE);

  assign bus.busy = busy_w;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  md_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op     (bus.md_op),
    .d1     (bus.d1),
    .d2     (bus.d2),
    .hi_in  (hi_q),
    .lo_in  (lo_q),
    .hi_out (nxt_hi),
    .lo_out (nxt_lo)
  );

  // accept requires !busy, so the accept and countdown branches never
  // overlap; the counter stops at zero because it only decrements while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else if (accept) begin
      case (kind)
        K_MUL: begin
          pend_hi_q <= nxt_hi;
          pend_lo_q <= nxt_lo;
          cnt_q     <= CW'(MUL_LAT);
        end
        K_DIV: begin
          pend_hi_q <= nxt_hi;
          pend_lo_q <= nxt_lo;
          cnt_q     <= CW'(DIV_LAT);
        end
        default: begin
          // MTHI/MTLO: md_arith already leaves the other register untouched.
          hi_q <= nxt_hi;
          lo_q <= nxt_lo;
        end
      endcase
    end else if (busy_w) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end
  end

  // A live (non-squashed) request while busy means the hazard unit failed
  // to stall; the request is dropped, but it indicates a controller bug.
  a_no_start_while_busy : assert property (
    @(posedge clk) disable iff (reset) !(bus.start && busy_w && !bus.req)
  ) else $error("md_unit_param: start asserted while busy");

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the E stage; successor to the fixed 32-bit, fixed-latency MD unit.
- Adds configurable data width and independent multiply/divide latencies.
- Defines divide-by-zero and signed-overflow results.
- Optional multiply-accumulate ops.
- Keeps the Start/Busy/Req contract the hazard unit already uses: stall any MD instruction in D while `start|busy`.

Parameters:
- WIDTH, 32, operand/HI/LO width (>=8, even)
- MUL_LAT, 5, busy cycles for mult/madd/msub (>=1)
- DIV_LAT, 10, busy cycles for div/divu (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle request from E; op valid this cycle
- md_op  in  4  operation code (md_pkg encoding)
- d1  in  WIDTH  rs operand (forwarded)
- d2  in  WIDTH  rt operand (forwarded)
- req  in  1  exception/interrupt taken this cycle; suppresses the E-stage request
- busy  out  1  long operation in progress
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (sync, active-high, highest priority): hi=0, lo=0, busy=0, counter=0, pending result=0. Reset mid-operation aborts it with no commit.
- Ops:
  - NONE
  - MULT/MULTU: {hi,lo} = d1*d2, 2*WIDTH-bit product, signed/unsigned.
  - DIV/DIVU: lo=quotient, hi=remainder. Truncation toward zero; remainder sign follows dividend.
  - MTHI/MTLO: single-cycle write, no busy.
- Accepted op: `start=1 && req=0 && busy=0 && md_op!=NONE`.
  - `req=1` in the same cycle: op discarded, no state change.
  - `start` while busy: ignored. This is a controller error; flag it under an assertion.
- Long op accepted at edge T:
  - Operands and result computed and latched into pending regs; counter loaded with LAT.
  - busy=1 during cycles T+1 … T+LAT.
  - At the edge ending cycle T+LAT: hi/lo <= pending, busy falls.
  - hi/lo hold old values throughout busy.
- MTHI/MTLO accepted at edge T: hi or lo updates at that edge; busy stays 0.
- req asserted while busy: no effect. An already-issued op completes and commits (older instruction).
- Counter: down-counter, width clog2(max(MUL_LAT,DIV_LAT))+1; busy = (counter!=0). No wrap: it stops at 0.
- Divide by zero (d2==0): busy timing is identical to a normal DIV; hi/lo keep their pre-op values (pending = current hi/lo).
- Signed overflow (d1 = -2^(WIDTH-1), d2 = -1): lo = -2^(WIDTH-1), hi = 0.
- Undefined md_op codes: treated as NONE.

Optional Feature:
- Macro: MD_UNIT_ACCUM_EN.
- Defined: MADD/MADDU/MSUB/MSUBU are enabled.
  - Operation: {hi,lo} ± product, modulo 2^(2*WIDTH), using MUL_LAT.
  - The accumulate base is the hi/lo value at the accept edge.
- Undefined: those four codes decode as NONE, with no busy and no state change.

Decomposition:
- Package md_pkg:
  - md_op_t 4-bit encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - Helper constant for counter width.
- Sub-module md_arith: purely combinational, parametrised by WIDTH.
  - Inputs: op, d1, d2, current hi/lo. Output: next {hi,lo}.
  - Owns all sign handling and the div0/overflow special cases.
- The top level holds the counter, pending registers and accept logic.

Test Plan:
- Reset check: reset=1 one cycle, then idle -> hi=0, lo=0, busy=0. Then MULT d1=-3, d2=7 (WIDTH=32, MUL_LAT=5) -> busy high exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB after busy falls; unchanged before.
- DIVU/DIV: DIVU 100/7 -> lo=14, hi=2 after 10 busy cycles. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Edge cases: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIV x/0 with hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo remain 0x11/0x22.
- Request suppression: start MULT with req=1 -> busy stays 0, hi/lo unchanged. MTHI 0xABCD with req=0 -> hi=0xABCD next cycle, busy=0.
- Busy interactions:
  - Start MULT, then req=1 in cycle 2 of busy -> product still commits at cycle 6.
  - start during busy -> ignored.
  - reset in cycle 3 of busy -> hi=lo=0, busy=0, no later commit.
- With MD_UNIT_ACCUM_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0. MSUB 2*3 from {0,0} -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. Without the macro -> code 7 produces no busy and no change.
